// File: rtl/matrix_mac_engine.sv
// Sequential C = A x B engine: snapshots both operand matrices on start, performs one
// multiply-accumulate per cycle and streams results row-major over a valid/ready handshake.
module matrix_mac_engine #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned MAX_DIM = 2,
  parameter int unsigned DIM_W   = $clog2(MAX_DIM) + 1,
  parameter int unsigned ACC_W   = 2 * DATA_W + $clog2(MAX_DIM)
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              start,
  input  logic [DIM_W-1:0]                  R1,
  input  logic [DIM_W-1:0]                  C1,
  input  logic [DIM_W-1:0]                  R2,
  input  logic [DIM_W-1:0]                  C2,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_1,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_2,
  output logic                              busy,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ACC_W-1:0]                  res_data,
  output logic [DIM_W-1:0]                  res_row,
  output logic [DIM_W-1:0]                  res_col,
  output logic                              res_last,
  output logic                              done,
  output logic                              err_dim
);

  localparam int unsigned NumEl = MAX_DIM * MAX_DIM;
  localparam int unsigned MatW  = NumEl * DATA_W;
  localparam int unsigned IdxW  = (NumEl > 1) ? $clog2(NumEl) : 1;
  localparam int unsigned ProdW = 2 * DATA_W;

  localparam logic [DIM_W-1:0] DimOne = DIM_W'(1);
  localparam logic [DIM_W-1:0] DimMax = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StMac,
    StOut,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
  logic [MatW-1:0]   m1_q, m1_d, m2_q, m2_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] a_el [NumEl];
  logic [DATA_W-1:0] b_el [NumEl];
  logic [IdxW-1:0]   a_idx, b_idx;
  logic [ProdW-1:0]  prod;
  logic              dim_bad, last_i, last_j, last_k;

  always_comb begin
    for (int e = 0; e < NumEl; e++) begin
      a_el[e] = m1_q[e*DATA_W +: DATA_W];
      b_el[e] = m2_q[e*DATA_W +: DATA_W];
    end
  end

  // Dense row-major packing: A uses stride C1, B uses stride C2.
  always_comb begin
    a_idx = IdxW'(i_q) * IdxW'(c1_q) + IdxW'(k_q);
    b_idx = IdxW'(k_q) * IdxW'(c2_q) + IdxW'(j_q);
    prod  = ProdW'(a_el[a_idx]) * ProdW'(b_el[b_idx]);
  end

  always_comb begin
    dim_bad = (r1_q == '0) || (c1_q == '0) || (r2_q == '0) || (c2_q == '0) ||
              (r1_q > DimMax) || (c1_q > DimMax) || (r2_q > DimMax) || (c2_q > DimMax) ||
              (c1_q != r2_q);
    last_i  = (i_q == r1_q - DimOne);
    last_j  = (j_q == c2_q - DimOne);
    last_k  = (k_q == c1_q - DimOne);
  end

  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    c1_d    = c1_q;
    r2_d    = r2_q;
    c2_d    = c2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          r1_d    = R1;
          c1_d    = C1;
          r2_d    = R2;
          c2_d    = C2;
          m1_d    = matrix_1;
          m2_d    = matrix_2;
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (dim_bad) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_W'(prod);
        if (last_k) begin
          state_d = StOut;
        end else begin
          k_d = k_q + DimOne;
        end
      end
      StOut: begin
        if (res_ready) begin
          acc_d = '0;
          k_d   = '0;
          if (last_j) begin
            j_d = '0;
            i_d = i_q + DimOne;
          end else begin
            j_d = j_q + DimOne;
          end
          state_d = (last_i && last_j) ? StDone : StMac;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      r1_q    <= '0;
      c1_q    <= '0;
      r2_q    <= '0;
      c2_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      c1_q    <= c1_d;
      r2_q    <= r2_d;
      c2_q    <= c2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Result fields are forced to zero whenever no element is being offered.
  always_comb begin
    busy      = (state_q != StIdle);
    res_valid = (state_q == StOut);
    res_data  = res_valid ? acc_q : '0;
    res_row   = res_valid ? i_q : '0;
    res_col   = res_valid ? j_q : '0;
    res_last  = res_valid && last_i && last_j;
    done      = (state_q == StDone);
    err_dim   = err_q;
  end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: a timeline/result-queue model checked every cycle, plus directed
// literal expectations and randomized operations with random backpressure.
module tb_matrix_mac_engine;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  R1 = '0, C1 = '0, R2 = '0, C2 = '0;
  logic [15:0] matrix_1 = '0, matrix_2 = '0;
  logic        res_ready = 1'b0;
  logic        busy, res_valid, res_last, done, err_dim;
  logic [8:0]  res_data;
  logic [1:0]  res_row, res_col;

  matrix_mac_engine dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .R1       (R1),
    .C1       (C1),
    .R2       (R2),
    .C2       (C2),
    .matrix_1 (matrix_1),
    .matrix_2 (matrix_2),
    .busy     (busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_row  (res_row),
    .res_col  (res_col),
    .res_last (res_last),
    .done     (done),
    .err_dim  (err_dim)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int data;
    int row;
    int col;
    int last;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_force = 1'b1;
  res_t exp_q[$];
  res_t obs_q[$];

  // Model state: operation timeline in absolute cycle numbers.
  bit m_act = 0, m_done_known = 0, m_err_flag = 0;
  int m_start_cyc = 0, m_done_cyc = 0, m_valid_from = 0, m_err_from = 0, m_c1 = 0;
  bit e_busy, e_valid, e_done, e_err, m_bad, m_lastpop;
  int m_r1, m_c1n, m_r2, m_c2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mel(input logic [15:0] m, input int idx);
    logic [15:0] s;
    s = m >> (idx * 4);
    return int'(s[3:0]);
  endfunction

  function automatic int cres(input logic [15:0] a, input logic [15:0] b, input int c1,
                              input int c2, input int i, input int j);
    int sum = 0;
    for (int k = 0; k < c1; k++) sum += mel(a, i * c1 + k) * mel(b, k * c2 + j);
    return sum;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(res_valid), 0);
    chk({tag, "_data"}, int'(res_data), 0);
    chk({tag, "_row"}, int'(res_row), 0);
    chk({tag, "_col"}, int'(res_col), 0);
    chk({tag, "_last"}, int'(res_last), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err_dim), 0);
  endtask

  // Compare process: model expectations versus DUT on every cycle.
  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      chk_all_zero("rst");
      m_act      = 0;
      m_err_flag = 0;
      exp_q.delete();
    end else begin
      e_busy  = m_act && (cyc > m_start_cyc) && (!m_done_known || cyc <= m_done_cyc);
      e_valid = e_busy && (exp_q.size() > 0) && (cyc >= m_valid_from);
      e_done  = m_act && m_done_known && (cyc == m_done_cyc);
      e_err   = m_err_flag && (cyc >= m_err_from);
      chk("busy", int'(busy), int'(e_busy));
      chk("res_valid", int'(res_valid), int'(e_valid));
      chk("done", int'(done), int'(e_done));
      chk("err_dim", int'(err_dim), int'(e_err));
      if (e_valid) begin
        chk("res_data", int'(res_data), exp_q[0].data);
        chk("res_row", int'(res_row), exp_q[0].row);
        chk("res_col", int'(res_col), exp_q[0].col);
        chk("res_last", int'(res_last), exp_q[0].last);
      end
      if (res_valid && res_ready)
        obs_q.push_back('{int'(res_data), int'(res_row), int'(res_col), int'(res_last)});
      if (e_valid && res_ready) begin
        m_lastpop = (exp_q[0].last != 0);
        void'(exp_q.pop_front());
        if (m_lastpop) begin
          m_done_known = 1;
          m_done_cyc   = cyc + 1;
        end else begin
          m_valid_from = cyc + m_c1 + 1;
        end
      end
      if (e_done) m_act = 0;
      if (start && !e_busy) begin
        m_r1  = int'(R1);
        m_c1n = int'(C1);
        m_r2  = int'(R2);
        m_c2  = int'(C2);
        m_bad = (m_r1 == 0) || (m_c1n == 0) || (m_r2 == 0) || (m_c2 == 0) || (m_r1 > 2) ||
                (m_c1n > 2) || (m_r2 > 2) || (m_c2 > 2) || (m_c1n != m_r2);
        m_act       = 1;
        m_start_cyc = cyc;
        m_err_flag  = m_bad;
        m_err_from  = cyc + 2;
        exp_q.delete();
        if (m_bad) begin
          m_done_known = 1;
          m_done_cyc   = cyc + 2;
        end else begin
          m_done_known = 0;
          m_c1         = m_c1n;
          m_valid_from = cyc + 2 + m_c1n;
          for (int i = 0; i < m_r1; i++)
            for (int j = 0; j < m_c2; j++)
              exp_q.push_back('{cres(matrix_1, matrix_2, m_c1n, m_c2, i, j), i, j,
                                 int'(i == m_r1 - 1 && j == m_c2 - 1)});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  task automatic run_op(input logic [1:0] r1, input logic [1:0] c1, input logic [1:0] r2,
                        input logic [1:0] c2, input logic [15:0] m1, input logic [15:0] m2,
                        input int exp_lat, input int exp_err, input int repulse,
                        input string tag);
    int lat;
    bit got;
    obs_q.delete();
    @(posedge CLK);
    #1;
    R1 = r1; C1 = c1; R2 = r2; C2 = c2;
    matrix_1 = m1; matrix_2 = m2;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    R1 = 2'($urandom); C1 = 2'($urandom); R2 = 2'($urandom); C2 = 2'($urandom);
    matrix_1 = 16'($urandom); matrix_2 = 16'($urandom);
    lat = 0;
    got = 0;
    while (lat < 400 && !got) begin
      @(negedge CLK);
      lat++;
      if (done) begin
        got = 1;
      end else begin
        @(posedge CLK);
        #1;
        start = (lat == repulse);
        if (start) begin
          matrix_1 = 16'($urandom); matrix_2 = 16'($urandom);
          R1 = 2'd2; C1 = 2'd2; R2 = 2'd2; C2 = 2'd2;
        end
      end
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    if (got && exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
    if (got && exp_err >= 0) chk({tag, "_err_at_done"}, int'(err_dim), exp_err);
    if (start) begin
      @(posedge CLK);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic chk_obs(input string tag, input int n, input int ed[4], input int er[4],
                         input int ec[4], input int el[4]);
    chk({tag, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      chk({tag, "_data"}, obs_q[i].data, ed[i]);
      chk({tag, "_row"}, obs_q[i].row, er[i]);
      chk({tag, "_col"}, obs_q[i].col, ec[i]);
      chk({tag, "_last"}, obs_q[i].last, el[i]);
    end
  endtask

  initial begin
    int ed[4], er[4], ec[4], el[4];
    int bad_tab[8][4];
    int r1, c1, r2, c2, rep;
    bad_tab = '{'{0, 2, 2, 2}, '{2, 0, 0, 2}, '{2, 2, 2, 0}, '{3, 2, 2, 2},
                '{2, 3, 3, 2}, '{2, 2, 2, 3}, '{1, 1, 2, 1}, '{0, 0, 0, 0}};
    er = '{0, 0, 1, 1};
    ec = '{0, 1, 0, 1};
    el = '{0, 0, 0, 1};

    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST_N = 1'b1;

    chk("model_c00", cres(16'h22F1, 16'h22F1, 2, 2, 0, 0), 31);
    chk("model_c11", cres(16'h22F1, 16'h22F1, 2, 2, 1, 1), 34);
    chk("model_max", cres(16'hFFFF, 16'hFFFF, 2, 2, 1, 0), 450);
    chk("model_nsq", cres(16'h0043, 16'h0065, 2, 1, 0, 0), 39);

    run_op(2'd2, 2'd2, 2'd2, 2'd2, 16'h22F1, 16'h22F1, 14, 0, 0, "sq");
    ed = '{31, 45, 6, 34};
    chk_obs("sq", 4, ed, er, ec, el);

    run_op(2'd2, 2'd2, 2'd2, 2'd2, 16'hFFFF, 16'hFFFF, 14, 0, 0, "max");
    ed = '{450, 450, 450, 450};
    chk_obs("max", 4, ed, er, ec, el);

    run_op(2'd1, 2'd2, 2'd2, 2'd1, 16'h0043, 16'h0065, 5, 0, 0, "nsq");
    ed = '{39, 0, 0, 0};
    chk_obs("nsq", 1, ed, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0});

    run_op(2'd2, 2'd2, 2'd1, 2'd2, 16'h1234, 16'h5678, 2, 1, 0, "err_k");
    chk_obs("err_k", 0, ed, er, ec, el);
    for (int t = 0; t < 8; t++) begin
      run_op(2'(bad_tab[t][0]), 2'(bad_tab[t][1]), 2'(bad_tab[t][2]), 2'(bad_tab[t][3]),
             16'hFFFF, 16'hFFFF, 2, 1, 0, "err_tab");
      chk_obs("err_tab", 0, ed, er, ec, el);
    end

    // Backpressure on the first element.
    rdy_force = 1'b0;
    fork
      run_op(2'd2, 2'd2, 2'd2, 2'd2, 16'h22F1, 16'h22F1, -1, 0, 0, "bp");
      begin
        for (int w = 0; w < 60 && !res_valid; w++) @(negedge CLK);
        chk("bp_valid_seen", int'(res_valid), 1);
        for (int n = 0; n < 5; n++) begin
          chk("bp_hold_data", int'(res_data), 31);
          chk("bp_hold_valid", int'(res_valid), 1);
          if (n < 4) @(negedge CLK);
        end
        rdy_force = 1'b1;
      end
    join
    ed = '{31, 45, 6, 34};
    chk_obs("bp", 4, ed, er, ec, el);

    // Reset during the MAC of element (1,0), then a clean rerun.
    @(posedge CLK);
    #1;
    R1 = 2'd2; C1 = 2'd2; R2 = 2'd2; C2 = 2'd2;
    matrix_1 = 16'h22F1; matrix_2 = 16'h22F1;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (7) @(posedge CLK);
    #2;
    chk("mid_busy", int'(busy), 1);
    RST_N = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    run_op(2'd2, 2'd2, 2'd2, 2'd2, 16'h22F1, 16'h22F1, 14, 0, 0, "post_rst");
    chk_obs("post_rst", 4, ed, er, ec, el);

    // Start re-pulsed while busy must be ignored.
    run_op(2'd2, 2'd2, 2'd2, 2'd2, 16'h22F1, 16'h22F1, 14, 0, 3, "repulse");
    chk_obs("repulse", 4, ed, er, ec, el);

    rdy_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        r1 = $urandom_range(1, 2);
        c1 = $urandom_range(1, 2);
        r2 = c1;
        c2 = $urandom_range(1, 2);
      end else begin
        r1 = $urandom_range(0, 3);
        c1 = $urandom_range(0, 3);
        r2 = $urandom_range(0, 3);
        c2 = $urandom_range(0, 3);
      end
      rep = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 8) : 0;
      run_op(2'(r1), 2'(c1), 2'(r2), 2'(c2), 16'($urandom), 16'($urandom), -1, -1, rep,
             "rand");
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    rdy_rand = 1'b0;

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1);
  end

endmodule
